// File: rtl/somador_sequencial_pkg.sv
// somador_sequencial_pkg: shared state encoding, default sizes and counter sizing helper
package somador_sequencial_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CHUNK = 1;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/somador_chunk.sv
// somador_chunk: combinational CHUNK-bit ripple-carry adder built from full adders
module somador_chunk #(
    parameter int CHUNK = 1
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);
    logic [CHUNK:0] c;
    assign c[0] = ci;
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign co = c[CHUNK];
endmodule

// File: rtl/somador_sequencial.sv
// somador_sequencial: sequential adder/subtractor processing CHUNK bits per cycle
module somador_sequencial
    import somador_sequencial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             overflow
);
    localparam int N = WIDTH / CHUNK;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    state_t state, state_n;
    logic [WIDTH-1:0] a, b;
    logic [CW-1:0] cnt;
    logic [CHUNK-1:0] ca, cb, cs;
    logic carry, co, last;
    assign last      = cnt == LAST;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign ca        = a[int'(cnt)*CHUNK +: CHUNK];
    assign cb        = b[int'(cnt)*CHUNK +: CHUNK];
    somador_chunk #(.CHUNK(CHUNK)) u_chunk (.a(ca), .b(cb), .ci(carry), .s(cs), .co(co));
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = in_valid  ? CALC : IDLE;
            CALC:    state_n = last      ? DONE : CALC;
            DONE:    state_n = out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end
    // B is stored pre-inverted in sub mode so CALC is always a plain add
    always_ff @(posedge clk) begin
        if (rst) begin
            a        <= '0;
            b        <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            s        <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (in_ready && in_valid) begin
            a     <= num1;
            b     <= sub ? ~num2 : num2;
            carry <= sub | cin;
            cnt   <= '0;
        end else if (state == CALC) begin
            s[int'(cnt)*CHUNK +: CHUNK] <= cs;
            carry <= co;
            cnt   <= cnt + CW'(1);
            if (last) begin
                cout     <= co;
                overflow <= (a[WIDTH-1] == b[WIDTH-1]) && (cs[CHUNK-1] != a[WIDTH-1]);
            end
        end
    end
endmodule

// File: tb/tb_somador_sequencial.sv
// tb_somador_sequencial: scoreboard bench for CHUNK=1 and CHUNK=4 instances at WIDTH=8
module tb_somador_sequencial;
    import somador_sequencial_pkg::*;
    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       o;
        int         acc;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic       iv[2], ir[2], ci[2], sb[2], ovd[2], ordy[2], co[2], ovf[2], prev[2];
    logic [7:0] n1[2], n2[2], so[2];
    int nch[2];
    int cyc = 0;
    int tests = 0;
    int fails = 0;
    exp_t q0[$], q1[$];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    somador_sequencial #(.WIDTH(DEF_WIDTH), .CHUNK(DEF_CHUNK)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .num1(n1[0]), .num2(n2[0]),
        .cin(ci[0]), .sub(sb[0]), .out_valid(ovd[0]), .out_ready(ordy[0]), .s(so[0]),
        .cout(co[0]), .overflow(ovf[0]));
    somador_sequencial #(.WIDTH(8), .CHUNK(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .num1(n1[1]), .num2(n2[1]),
        .cin(ci[1]), .sub(sb[1]), .out_valid(ovd[1]), .out_ready(ordy[1]), .s(so[1]),
        .cout(co[1]), .overflow(ovf[1]));
    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    function automatic int qsize(input int d);
        return d == 0 ? q0.size() : q1.size();
    endfunction
    task automatic mon(input int d);
        exp_t e;
        if (ovd[d] && !prev[d]) begin
            if (qsize(d) == 0) chk($sformatf("unexpected_result%0d", d), 1, 0);
            else begin
                e = (d == 0) ? q0[0] : q1[0];
                chk($sformatf("latency%0d", d), cyc - e.acc, nch[d]);
            end
        end
        if (ovd[d] && ordy[d] && qsize(d) > 0) begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("s%0d", d), int'(so[d]), int'(e.s));
            chk($sformatf("cout%0d", d), int'(co[d]), int'(e.c));
            chk($sformatf("overflow%0d", d), int'(ovf[d]), int'(e.o));
        end
        prev[d] = ovd[d];
    endtask
    always @(negedge clk) if (!rst) begin
        mon(0);
        mon(1);
    end
    task automatic op(input int d, input logic [7:0] x, input logic [7:0] y, input logic c,
                      input logic sbit, input logic [7:0] es, input logic ec, input logic eo,
                      input bit keepv);
        exp_t e;
        int k = 0;
        while (!ir[d] && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (!ir[d]) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        iv[d] = 1'b1; n1[d] = x; n2[d] = y; ci[d] = c; sb[d] = sbit;
        @(posedge clk); #1;
        e.s = es; e.c = ec; e.o = eo; e.acc = cyc;
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
        n1[d] = ~x; n2[d] = x ^ y; ci[d] = ~c; sb[d] = ~sbit;
        if (keepv) begin
            k = 0;
            while (!ovd[d] && k < 50) begin
                @(posedge clk); #1;
                k++;
            end
        end
        iv[d] = 1'b0;
    endtask
    task automatic drain();
        int k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);
    endtask
    initial begin
        nch[0] = 8; nch[1] = 2;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 0; n1[d] = 0; n2[d] = 0; ci[d] = 0; sb[d] = 0; ordy[d] = 1; prev[d] = 0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("rst_in_ready", int'(ir[d]), 1);
            chk("rst_out_valid", int'(ovd[d]), 0);
            chk("rst_s", int'(so[d]), 0);
            chk("rst_cout", int'(co[d]), 0);
            chk("rst_overflow", int'(ovf[d]), 0);
        end
        op(0, 8'd200, 8'd100, 0, 0, 8'h2C, 1, 0, 0);
        op(0, 8'd5,   8'd7,   0, 1, 8'hFE, 0, 0, 0);
        op(0, 8'd7,   8'd5,   1, 1, 8'h02, 1, 0, 0);
        op(0, 8'd127, 8'd1,   0, 0, 8'h80, 0, 1, 0);
        op(0, 8'hFF,  8'h00,  1, 0, 8'h00, 1, 0, 0);
        op(0, 8'h80,  8'h01,  0, 1, 8'h7F, 1, 1, 1);
        op(0, 8'h55,  8'hAA,  1, 0, 8'h00, 1, 0, 0);
        op(0, 8'h00,  8'h00,  0, 1, 8'h00, 1, 0, 0);
        op(1, 8'hF0,  8'h1F,  0, 0, 8'h0F, 1, 0, 0);
        op(1, 8'h7F,  8'h7F,  1, 0, 8'hFF, 0, 1, 1);
        op(1, 8'h10,  8'h20,  1, 1, 8'hF0, 0, 0, 0);
        drain();
        ordy[0] = 1'b0;
        op(0, 8'h12, 8'h34, 0, 0, 8'h46, 0, 0, 0);
        for (int k = 0; k < 20 && !ovd[0]; k++) begin
            @(posedge clk); #1;
        end
        chk("hold_reached_done", int'(ovd[0]), 1);
        for (int k = 0; k < 5; k++) begin
            n1[0] = 8'($urandom); n2[0] = 8'($urandom);
            @(posedge clk); #1;
            chk("hold_s", int'(so[0]), 8'h46);
            chk("hold_in_ready", int'(ir[0]), 0);
            chk("hold_out_valid", int'(ovd[0]), 1);
        end
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", int'(ir[0]), 1);
        chk("release_out_valid", int'(ovd[0]), 0);
        drain();
        iv[0] = 1'b1; n1[0] = 8'hFF; n2[0] = 8'hFF; ci[0] = 1; sb[0] = 0;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", int'(ir[0]), 1);
        chk("midrst_out_valid", int'(ovd[0]), 0);
        chk("midrst_s", int'(so[0]), 0);
        chk("midrst_cout", int'(co[0]), 0);
        chk("midrst_overflow", int'(ovf[0]), 0);
        op(0, 8'h3C, 8'h0F, 0, 1, 8'h2D, 1, 0, 0);
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/somador_sequencial.md
SOMADOR_SEQUENCIAL -- requirements
Module: somador_sequencial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand/result width in bits, >= 2.
REQ-002 The block SHALL have parameter CHUNK, default 1: bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-007 The block SHALL have ports num1 and num2, input, WIDTH bits each: operands A and B.
REQ-008 The block SHALL have port cin, input, 1 bit: carry-in, used in add mode only.
REQ-009 The block SHALL have port sub, input, 1 bit: 0 = A+B+cin, 1 = A-B.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result present.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-012 The block SHALL have port s, output, WIDTH bits: sum/difference.
REQ-013 The block SHALL have port cout, output, 1 bit: carry-out of MSB; in sub mode, 1 = no borrow.
REQ-014 The block SHALL have port overflow, output, 1 bit: two's-complement signed overflow.

Function
REQ-015 The block SHALL use FSM states IDLE, CALC and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 Accept: on an edge with in_valid=1 in IDLE, the block SHALL register num1, num2 and sub, set the effective carry (cin if sub=0, 1 if sub=1), clear the chunk counter, and enter CALC.
REQ-018 In sub mode the registered B SHALL be bitwise inverted (A + ~B + 1).
REQ-019 Each CALC cycle SHALL add chunk index cnt (bits cnt*CHUNK .. cnt*CHUNK+CHUNK-1) of A, B and the carry register, write the chunk result into s, and update the carry register.
REQ-020 After chunk WIDTH/CHUNK-1 the block SHALL enter DONE, with cout = final carry and overflow = (A[MSB]==Beff[MSB]) && (s[MSB]!=A[MSB]).
REQ-021 Latency SHALL be exactly WIDTH/CHUNK cycles: out_valid rises on the edge WIDTH/CHUNK cycles after the accept edge.
REQ-022 In DONE, s, cout and overflow SHALL hold stable until an edge with out_ready=1; on that edge the block SHALL return to IDLE.
REQ-023 The block SHALL need no cycle between completion and next accept beyond the DONE->IDLE edge; back-to-back throughput SHALL be one result per WIDTH/CHUNK+2 cycles.
REQ-024 num1, num2, cin and sub changes outside the accept edge SHALL have no effect on an operation in progress.
REQ-025 in_valid during CALC or DONE SHALL be ignored (not queued).
REQ-026 Wrap-around: results SHALL be modulo 2^WIDTH, with carry reported only in cout.

Reset
REQ-027 On a clock edge with rst=1 the block SHALL enter IDLE with s=0, cout=0, overflow=0, out_valid=0, in_ready=1, counter and carry cleared.
REQ-028 rst SHALL take priority over every other event, including mid-CALC and in DONE with out_ready=1; the interrupted result SHALL be discarded.

Structure
REQ-029 State encodings (IDLE=0, CALC=1, DONE=2) and default WIDTH/CHUNK values SHALL reside in a shared include file used by the block and its bench.
REQ-030 The per-cycle adder SHALL be a combinational sub-module somador_chunk (CHUNK-bit ripple of full adders, ports a, b, ci, s, co); the block SHALL instantiate it once.
REQ-031 The counter width SHALL be clog2(WIDTH/CHUNK), minimum 1 bit.

Verification
REQ-032 WIDTH=8, CHUNK=1: add 200+100, cin=0 -> s=0x2C, cout=1, overflow=0, out_valid 8 cycles after accept.
REQ-033 WIDTH=8: sub 5-7 -> s=0xFE, cout=0, overflow=0; sub 7-5 -> s=0x02, cout=1.
REQ-034 WIDTH=8: add 127+1, cin=0 -> s=0x80, overflow=1; add 0xFF+0x00, cin=1 -> s=0x00, cout=1.
REQ-035 Hold out_ready=0 for 5 cycles in DONE while num1/num2 change -> s unchanged, in_ready=0; release -> IDLE next edge.
REQ-036 Assert rst at CALC cycle 3 -> next edge IDLE, all outputs 0, in_ready=1; a new operation then completes correctly.
REQ-037 WIDTH=8, CHUNK=4: 0xF0+0x1F -> s=0x0F, cout=1, latency 2 cycles.
